// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared types and constants for the SPI-to-RAM datapath
//
// Contents:
//   DEFAULT_ADDR_SIZE  default width of the address/data field
//   state_e            SPI slave FSM states
//   CMD_*              2-bit command codes carried in frame bits [9:8]
//   cnt_width()        bit-counter width able to hold a full frame or byte
package spi_ram_pkg;

    localparam int DEFAULT_ADDR_SIZE = 8;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    localparam logic [1:0] CMD_WRITE_ADDRESS = 2'b00;
    localparam logic [1:0] CMD_WRITE_DATA    = 2'b01;
    localparam logic [1:0] CMD_READ_ADDRESS  = 2'b10;
    localparam logic [1:0] CMD_READ_DATA     = 2'b11;

    // The counter must reach max(frame_w, addr_size) + 1 without wrapping:
    // the tx side counts one past the last bit to mark the byte as sent.
    function automatic int cnt_width(input int frame_w, input int addr_size);
        int m;
        m = (frame_w > addr_size) ? frame_w : addr_size;
        return $clog2(m + 2);
    endfunction

endpackage

// File: rtl/spi_slave_if_if.sv
// rtl/spi_slave_if_if.sv - SPI pins and RAM-side handshake bundle
//
// Signals:
//   SS_n, MOSI, MISO   SPI serial pins (slave select active low, MSB first)
//   rx_data, rx_valid  assembled frame towards RAM din, one-cycle strobe
//   tx_data, tx_valid  read data from RAM dout with its valid flag
// Modports:
//   slave   view used by spi_slave_if
//   master  view used by the SPI master / RAM side
interface spi_slave_if_if
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
    parameter int FRAME_W   = ADDR_SIZE + 2
);

    logic                 SS_n;
    logic                 MOSI;
    logic                 MISO;
    logic [FRAME_W-1:0]   rx_data;
    logic                 rx_valid;
    logic [ADDR_SIZE-1:0] tx_data;
    logic                 tx_valid;

    modport slave (
        input  SS_n,
        input  MOSI,
        input  tx_data,
        input  tx_valid,
        output MISO,
        output rx_data,
        output rx_valid
    );

    modport master (
        output SS_n,
        output MOSI,
        output tx_data,
        output tx_valid,
        input  MISO,
        input  rx_data,
        input  rx_valid
    );

endinterface

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - shift register with parallel load and bit counter
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear of data and counter (highest priority)
//   load        parallel load of din; counter set to 1 (first bit presented)
//   shift       shift left by one, sin enters at bit 0; counter increments
//   sin         serial input
//   din         parallel load data
//   q           register contents; q[WIDTH-1] is the serial output
//   cnt         number of bits shifted in / presented since clear
module spi_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic             sin,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            cnt <= '0;
        end else if (clr) begin
            q   <= '0;
            cnt <= '0;
        end else if (load) begin
            q   <= din;
            cnt <= CNT_W'(1);
        end else if (shift) begin
            q   <= {q[WIDTH-2:0], sin};
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI slave front end: MOSI frames to RAM words, RAM bytes to MISO
//
// Ports:
//   clk    SPI serial clock shared with the RAM, rising-edge sampling
//   rst_n  asynchronous active-low reset
//   bus    spi_slave_if_if.slave: SS_n/MOSI/MISO, rx_data/rx_valid, tx_data/tx_valid
//
// Frame: one select bit (0 write path, 1 read path) then FRAME_W payload bits,
// MSB first. The payload is forwarded unmodified with a one-cycle rx_valid.
// A read-path frame after a completed read-address frame is a read-data frame:
// once received, the first tx_valid latches tx_data and shifts it out on MISO.
module spi_slave_if
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
    parameter int FRAME_W   = ADDR_SIZE + 2
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_slave_if_if.slave bus
);

    localparam int CNT_W = cnt_width(FRAME_W, ADDR_SIZE);

    state_e               state;
    state_e               state_next;

    logic                 rd_addr_done;
    logic                 rx_valid_q;

    logic [FRAME_W-1:0]   rx_q;
    logic [CNT_W-1:0]     rx_cnt;
    logic [ADDR_SIZE-1:0] tx_q;
    logic [CNT_W-1:0]     tx_cnt;

    logic                 in_frame;
    logic                 rx_shift;
    logic                 rx_last;
    logic                 rx_done;
    logic                 tx_load;
    logic                 tx_shift;
    logic                 tx_last;

    // Only the MSB of tx_q drives MISO; the lower bits just feed the shift chain.
    logic [ADDR_SIZE-2:0] unused_tx_low;
    assign unused_tx_low = tx_q[ADDR_SIZE-2:0];

    // Receiving states share the same deserialiser; SS_n high clears both
    // registers so an aborted frame leaves nothing behind.
    assign in_frame = ((state == WRITE) || (state == READ_ADD) || (state == READ_DATA))
                      && !bus.SS_n;
    assign rx_done  = (rx_cnt == CNT_W'(FRAME_W));
    assign rx_shift = in_frame && (rx_cnt < CNT_W'(FRAME_W));
    assign rx_last  = rx_shift && (rx_cnt == CNT_W'(FRAME_W - 1));

    // tx_cnt: 0 = waiting for tx_valid, 1..ADDR_SIZE = bit on MISO,
    // ADDR_SIZE+1 = byte sent; it never returns to 0 inside a frame, so a
    // late tx_valid cannot restart the transmit.
    assign tx_load  = in_frame && (state == READ_DATA) && rx_done
                      && (tx_cnt == '0) && bus.tx_valid;
    assign tx_shift = in_frame && (state == READ_DATA)
                      && (tx_cnt != '0) && (tx_cnt <= CNT_W'(ADDR_SIZE));
    assign tx_last  = tx_shift && (tx_cnt == CNT_W'(ADDR_SIZE));

    spi_shift_reg #(
        .WIDTH (FRAME_W),
        .CNT_W (CNT_W)
    ) u_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.SS_n),
        .load  (1'b0),
        .shift (rx_shift),
        .sin   (bus.MOSI),
        .din   ('0),
        .q     (rx_q),
        .cnt   (rx_cnt)
    );

    spi_shift_reg #(
        .WIDTH (ADDR_SIZE),
        .CNT_W (CNT_W)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.SS_n),
        .load  (tx_load),
        .shift (tx_shift),
        .sin   (1'b0),
        .din   (bus.tx_data),
        .q     (tx_q),
        .cnt   (tx_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // rd_addr_done survives aborts so an interrupted read-data can be retried;
    // only a fully shifted-out byte (or reset) clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q   <= 1'b0;
            rd_addr_done <= 1'b0;
        end else begin
            rx_valid_q <= rx_last;
            if (rx_last && (state == READ_ADD)) begin
                rd_addr_done <= 1'b1;
            end else if (tx_last) begin
                rd_addr_done <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!bus.SS_n) begin
                    state_next = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (bus.SS_n) begin
                    state_next = IDLE;
                end else if (!bus.MOSI) begin
                    state_next = WRITE;
                end else if (!rd_addr_done) begin
                    state_next = READ_ADD;
                end else begin
                    state_next = READ_DATA;
                end
            end
            default: begin
                if (bus.SS_n) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // tx_q is zero whenever no byte is in flight (reset, clear, fully
    // shifted), so its MSB is directly the MISO level.
    always_comb begin
        bus.MISO     = (state == READ_DATA) ? tx_q[ADDR_SIZE-1] : 1'b0;
        bus.rx_data  = rx_q;
        bus.rx_valid = rx_valid_q;
    end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- Serial front end of the SPI-to-RAM datapath.
- Deserialises MOSI frames into 10-bit command/data words: bits[9:8] are the command, bits[7:0] the address or data. Each word goes to the RAM with a one-cycle rx_valid strobe.
- On a read-data command, captures the RAM's 8-bit tx_data/tx_valid response and shifts it out on MISO, MSB first.
- clk is the SPI serial clock, shared with the RAM.

Parameters:
- ADDR_SIZE, 8, width of address/data field and of tx_data.
- FRAME_W, ADDR_SIZE+2, width of rx_data payload (command + field).

Ports:
- clk  input  1  SPI/system clock; all sampling on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SS_n  input  1  slave select, active low; high aborts/ends frame.
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first.
- rx_data  output  FRAME_W  assembled payload to RAM din.
- rx_valid  output  1  one-cycle strobe, rx_data valid.
- tx_data  input  ADDR_SIZE  read data from RAM dout.
- tx_valid  input  1  RAM read data valid.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, MISO=0, rx_data=0, rx_valid=0, bit counter=0, rd_addr_done=0, tx shift register=0.
- Frame format: 1 select bit, then FRAME_W payload bits MSB first.
  - Select bit 0 = write path; select bit 1 = read path.
  - Payload is forwarded unmodified; no select/command consistency check.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
  - IDLE: MISO=0. SS_n=0 sampled -> CHK_CMD.
  - CHK_CMD: SS_n=1 -> IDLE. Otherwise sample MOSI:
    - 0 -> WRITE.
    - 1 and rd_addr_done=0 -> READ_ADD.
    - 1 and rd_addr_done=1 -> READ_DATA.
  - WRITE, READ_ADD: shift in FRAME_W bits, one per edge.
    - After the FRAME_W-th bit, rx_data=payload and rx_valid=1 for exactly one cycle.
    - Further MOSI bits are ignored until SS_n=1.
    - READ_ADD sets rd_addr_done=1 on its rx_valid.
  - READ_DATA receive phase: same as WRITE (rx_valid pulse). Then wait for tx_valid.
  - READ_DATA transmit phase:
    - On the first edge with tx_valid=1, latch tx_data and drive MISO=tx_data[7] from that edge.
    - The next 7 edges drive bits 6..0.
    - After bit 0, MISO=0, rd_addr_done cleared, tx_valid ignored until the next frame.
- Timing: SS_n low at edge 0, select bit at edge 1, payload bits 9..0 at edges 2..11, rx_valid high in the cycle after edge 11.
- SS_n=1 in any non-IDLE state:
  - Next state IDLE; counter cleared; rx_valid=0; MISO=0.
  - A partial frame is never forwarded.
  - rd_addr_done is retained. An aborted transmit also retains rd_addr_done, so the data read can be retried.
- tx_valid arriving before the receive phase completes is ignored.
- Reset mid-frame or mid-transmit: immediate return to reset values, MISO=0 asynchronously.
- Counter wide enough for max(FRAME_W, ADDR_SIZE); never wraps within a frame.

Decomposition:
- Shared package spi_ram_pkg:
  - state enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA);
  - command constants WRITE_ADDRESS=2'b00, WRITE_DATA=2'b01, READ_ADDRESS=2'b10, READ_DATA=2'b11;
  - ADDR_SIZE default.
- Optional sub-module spi_shift_reg: serial-in/parallel-out and parallel-load/serial-out register with bit counter, instantiated once for rx and once for tx. Otherwise keep flat.

Test Plan:
- Write address: SS_n=0, MOSI=0 then 00_0011_1100 -> rx_data=10'h03C, rx_valid=1 for exactly one cycle after edge 11; SS_n=1 -> IDLE.
- Write data: select 0, payload 01_1010_0101 -> rx_data=10'h1A5, single rx_valid pulse; rd_addr_done stays 0.
- Read address: select 1, payload 10_0011_1100 -> rx_data=10'h23C, rx_valid pulse, rd_addr_done=1.
- Read data: select 1, payload 11_0000_0000 -> rx_data=10'h300 pulse; bench drives tx_data=8'hA5 with tx_valid -> MISO 1,0,1,0,0,1,0,1 on 8 consecutive cycles, then 0; rd_addr_done=0.
- Abort: SS_n raised after 5 payload bits -> no rx_valid, state IDLE next cycle. A following full write frame 10'h1FF is received correctly.
- Reset: rst_n pulsed low during MISO bit 3 of a read -> MISO=0 and rx_valid=0 immediately, state IDLE, rd_addr_done=0; the next read frame goes to READ_ADD.
